// File: rtl/shift_scale_pkg.sv
// Shared widths, FSM encoding and the widening shift for shift_scale_arbiter.
package shift_scale_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 4;
  localparam int SH_W   = 2;
  localparam int OUT_W  = 6;
  localparam int ID_W   = 2;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  // Computed at 32 bits so callers with any width set can narrow the result themselves.
  function automatic logic [31:0] full_shift(input logic [31:0] d, input logic [31:0] sh);
    return d << sh;
  endfunction

endpackage

// File: rtl/shift_scale_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o
);

  logic [ID_W-1:0] ptr_q, ptr_d, idx;
  logic            found;

  // N_REQ is a power of two, so ID_W-bit addition wraps modulo N_REQ.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr_q + ID_W'(k);
      if (!found && en_i && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
    ptr_d = found ? gnt_idx_o + 1'b1 : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shift_scale_arbiter.sv
// Round-robin shared shift-left scaler with one registered output stage.
// Define SATURATE_EN to clamp overflowing results to all ones and flag out_ovf.
module shift_scale_arbiter
  import shift_scale_pkg::*;
#(
  parameter int N_REQ  = shift_scale_pkg::N_REQ,
  parameter int DATA_W = shift_scale_pkg::DATA_W,
  parameter int SH_W   = shift_scale_pkg::SH_W,
  parameter int OUT_W  = shift_scale_pkg::OUT_W,
  parameter int ID_W   = shift_scale_pkg::ID_W,
  parameter int CNT_W  = shift_scale_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*SH_W-1:0]   req_shamt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_ovf,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int FULL_W = DATA_W + (1 << SH_W) - 1;

  logic [N_REQ-1:0][DATA_W-1:0] data_a;
  logic [N_REQ-1:0][SH_W-1:0]   sh_a;
  logic [N_REQ-1:0]             gnt;
  logic [ID_W-1:0]              gnt_idx;
  logic                         gnt_any, can_accept;
  logic [FULL_W-1:0]            full;
  logic [OUT_W-1:0]             res_d, data_q;
  logic [ID_W-1:0]              id_q;
  logic                         valid_q;
  logic [CNT_W-1:0]             stall_q;
  state_e                       state_q, state_d;

  assign data_a     = req_data;
  assign sh_a       = req_shamt;
  assign can_accept = !valid_q || out_ready;
  assign gnt_any    = |gnt;
  assign req_ready  = gnt;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .en_i      (can_accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign full = FULL_W'(full_shift(32'(data_a[gnt_idx]), 32'(sh_a[gnt_idx])));

`ifdef SATURATE_EN
  logic ovf_d, ovf_q;
  assign ovf_d   = |full[FULL_W-1:OUT_W];
  assign res_d   = ovf_d ? '1 : full[OUT_W-1:0];
  assign out_ovf = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (gnt_any) ovf_q <= ovf_d;
  end
`else
  logic unused_hi;
  assign unused_hi = ^full[FULL_W-1:OUT_W];
  assign res_d     = full[OUT_W-1:0];
  assign out_ovf   = 1'b0;
`endif

  // A grant always reloads, so drain-and-refill in one cycle has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else if (gnt_any) begin
      valid_q <= 1'b1;
      data_q  <= res_d;
      id_q    <= gnt_idx;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      stall_q <= '0;
    else if (valid_q && !out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any) state_d = RUN;
      RUN:     if (!out_ready) state_d = HOLD;
               else if (!gnt_any) state_d = IDLE;
      HOLD:    if (out_ready) state_d = gnt_any ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_shift_scale_arbiter.sv
// Directed bench for shift_scale_arbiter: vector table plus multi-cycle sequences.
// CNT_W is narrowed to 2 so the stall counter saturation point is reachable.
module tb_shift_scale_arbiter;
  import shift_scale_pkg::*;

  localparam int NR = 4, DW = 4, SW = 2, OW = 6, IW = 2, CW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*DW-1:0]  req_data;
  logic [NR*SW-1:0]  req_shamt;
  logic              out_valid, out_ready, out_ovf;
  logic [OW-1:0]     out_data;
  logic [IW-1:0]     out_id;
  logic [CW-1:0]     stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  shift_scale_arbiter #(
    .N_REQ(NR), .DATA_W(DW), .SH_W(SW), .OUT_W(OW), .ID_W(IW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shamt(req_shamt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_ovf(out_ovf), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rq;
    logic [3:0] d;
    logic [1:0] sh;
    logic [5:0] trunc;
    logic [5:0] sat;
    logic       ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic [3:0] d, input logic [1:0] s);
    req_data[r*DW +: DW]  = d;
    req_shamt[r*SW +: SW] = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[8];
  logic [5:0] exp_d;
  logic       exp_o;

  initial begin
    vt[0] = '{0, 4'h3, 2'd2, 6'd12, 6'd12, 1'b0};
    vt[1] = '{1, 4'hF, 2'd3, 6'd56, 6'd63, 1'b1};
    vt[2] = '{2, 4'h5, 2'd0, 6'd5,  6'd5,  1'b0};
    vt[3] = '{3, 4'h9, 2'd2, 6'd36, 6'd36, 1'b0};
    vt[4] = '{2, 4'h8, 2'd3, 6'd0,  6'd63, 1'b1};
    vt[5] = '{3, 4'h7, 2'd3, 6'd56, 6'd56, 1'b0};
    vt[6] = '{0, 4'hF, 2'd2, 6'd60, 6'd60, 1'b0};
    vt[7] = '{1, 4'hC, 2'd3, 6'd32, 6'd63, 1'b1};

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_shamt = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_id",    32'(out_id), 0);
    chk("rst_ovf",   32'(out_ovf), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    #10 rst_n = 1'b1;
    tick();

    // Single-request vectors, each from a drained or draining output stage.
    for (int i = 0; i < 8; i++) begin
      req_valid = 4'(1 << vt[i].rq);
      drive(vt[i].rq, vt[i].d, vt[i].sh);
      #1 chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(1 << vt[i].rq));
      tick();
      req_valid = '0;
`ifdef SATURATE_EN
      exp_d = vt[i].sat;   exp_o = vt[i].ovf;
`else
      exp_d = vt[i].trunc; exp_o = 1'b0;
`endif
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_data", i),  32'(out_data), 32'(exp_d));
      chk($sformatf("vec%0d_id", i),    32'(out_id), 32'(vt[i].rq));
      chk($sformatf("vec%0d_ovf", i),   32'(out_ovf), 32'(exp_o));
      chk($sformatf("vec%0d_state", i), 32'(dut.state_q), 32'(RUN));
    end
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_state", 32'(dut.state_q), 32'(IDLE));
    chk("ptr_pre_sparse", 32'(dut.u_arb.ptr_q), 2);

    // Sparse: requesters 1 and 3 with pointer at 2.
    req_valid = 4'b1010; drive(1, 4'h1, 2'd0); drive(3, 4'h2, 2'd0);
    #1 chk("sparse_gnt3", 32'(req_ready), 32'(4'b1000));
    tick();
    chk("sparse_id3",  32'(out_id), 3);
    chk("sparse_ptr0", 32'(dut.u_arb.ptr_q), 0);
    #1 chk("sparse_gnt1", 32'(req_ready), 32'(4'b0010));
    tick();
    chk("sparse_id1",  32'(out_id), 1);
    chk("sparse_ptr2", 32'(dut.u_arb.ptr_q), 2);
    req_valid = '0;
    tick();

    // Backpressure: hold a result for 3 cycles, then refill from requester 2.
    req_valid = 4'b0001; drive(0, 4'h1, 2'd0);
    tick();
    req_valid = 4'b0100; drive(2, 4'h2, 2'd1); out_ready = 1'b0;
    #1 chk("bp_ready0", 32'(req_ready), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp%0d_valid", c), 32'(out_valid), 1);
      chk($sformatf("bp%0d_data", c),  32'(out_data), 1);
      chk($sformatf("bp%0d_id", c),    32'(out_id), 0);
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 0);
      chk($sformatf("bp%0d_state", c), 32'(dut.state_q), 32'(HOLD));
    end
    chk("bp_stall", 32'(stall_cnt), 3);
    out_ready = 1'b1;
    #1 chk("bp_release_gnt", 32'(req_ready), 32'(4'b0100));
    tick();
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_data",  32'(out_data), 4);
    chk("bp_next_id",    32'(out_id), 2);
    chk("bp_next_state", 32'(dut.state_q), 32'(RUN));
    chk("bp_stall_keep", 32'(stall_cnt), 3);
    req_valid = '0;
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // Further stalls must not wrap the counter; then reset mid-HOLD.
    req_valid = 4'b0001; drive(0, 4'h3, 2'd0);
    tick();
    req_valid = '0; out_ready = 1'b0;
    tick(); tick();
    chk("sat_state", 32'(dut.state_q), 32'(HOLD));
    chk("sat_stall", 32'(stall_cnt), 3);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data",  32'(out_data), 0);
    chk("mid_rst_id",    32'(out_id), 0);
    chk("mid_rst_stall", 32'(stall_cnt), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("mid_rst_ptr",   32'(dut.u_arb.ptr_q), 0);
    #2 rst_n = 1'b1;

    // Fairness: all valid, grants 0,1,2,3,0,1 back to back.
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int r = 0; r < NR; r++) drive(r, 4'(r + 1), 2'd1);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("fair%0d_gnt", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("fair%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("fair%0d_id", k),    32'(out_id), 32'(k % 4));
      chk($sformatf("fair%0d_data", k),  32'(out_data), 32'(2 * ((k % 4) + 1)));
      #1;
    end
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
